// File: rtl/data_memory_lsu.sv
// Byte-addressed load/store unit in front of a word-wide data array: RISC-V sizes,
// sign/zero extension, byte-lane store merging, wait states and access-error flags.
module data_memory_lsu #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH_WORDS = 7920,
    parameter int LATENCY     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [31:0]           req_write_data,
    output logic                  resp_valid,
    output logic [31:0]           resp_read_data,
    output logic                  resp_error
);

    localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic [31:0]             rd_word_q;

    logic [31:0]             mem [DEPTH_WORDS];

    logic                    go_resp;
    logic                    acc_wr;
    logic [1:0]              acc_size;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [31:0]             acc_wdata;
    logic [31:0]             acc_idx32;
    logic [MEM_AW-1:0]       mem_idx;
    logic                    acc_err;
    logic [3:0]              byte_en;
    logic [31:0]             wr_lanes;
    logic                    mem_we;
    logic [7:0]              lane_byte;
    logic [15:0]             lane_half;

    // With LATENCY=0 the array is accessed on the accept edge itself, so the
    // access uses the live request in IDLE and the latched copy otherwise.
    always_comb begin
        if (state_q == IDLE) begin
            acc_wr    = req_write;
            acc_size  = req_size;
            acc_addr  = req_address;
            acc_wdata = req_write_data;
        end else begin
            acc_wr    = wr_q;
            acc_size  = size_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        acc_idx32 = 32'(acc_addr >> 2);
        mem_idx   = acc_idx32[MEM_AW-1:0];
        case (acc_size)
            2'b00:   acc_err = 1'b0;
            2'b01:   acc_err = acc_addr[0];
            2'b10:   acc_err = (acc_addr[1:0] != 2'b00);
            default: acc_err = 1'b1;
        endcase
        if (acc_idx32 >= $unsigned(DEPTH_WORDS)) begin
            acc_err = 1'b1;
        end
    end

    always_comb begin
        case (acc_size)
            2'b00: begin
                byte_en  = 4'b0001 << acc_addr[1:0];
                wr_lanes = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                byte_en  = acc_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{acc_wdata[15:0]}};
            end
            default: begin
                byte_en  = 4'b1111;
                wr_lanes = acc_wdata;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        go_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_address;
                    wdata_d = req_write_data;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        err_d = go_resp & acc_err;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    // Reset on the commit edge drops the store; erroneous accesses never write.
    assign mem_we = go_resp & ~reset & acc_wr & ~acc_err;

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && byte_en[i]) begin
                mem[mem_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
        if (go_resp) begin
            rd_word_q <= mem[mem_idx];
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_error = err_q;

    always_comb begin
        lane_byte      = rd_word_q[8*addr_q[1:0] +: 8];
        lane_half      = rd_word_q[16*addr_q[1] +: 16];
        resp_read_data = 32'd0;
        if ((state_q == RESP) && !err_q && !wr_q) begin
            case (size_q)
                2'b00:   resp_read_data = {{24{~uns_q & lane_byte[7]}}, lane_byte};
                2'b01:   resp_read_data = {{16{~uns_q & lane_half[15]}}, lane_half};
                default: resp_read_data = rd_word_q;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench: three LSU instances (LATENCY 0, 1, 3) driven with directed
// requests; per-instance monitors pop expected responses and check data, error, timing.
module tb_data_memory_lsu;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        int          cyc;
        int          id;
    } exp_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          tid   = 0;
    int          last_acc [3];

    logic        v    [3];
    logic        rdy  [3];
    logic        wr   [3];
    logic [1:0]  sz   [3];
    logic        uns  [3];
    logic [15:0] addr [3];
    logic [31:0] wd   [3];
    logic        rv   [3];
    logic [31:0] rd   [3];
    logic        err  [3];

    exp_t        exp_q [3][$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        exp_t e_mon;

        data_memory_lsu #(
            .ADDR_WIDTH (16),
            .DEPTH_WORDS(7920),
            .LATENCY    ((gi == 0) ? 0 : ((gi == 1) ? 1 : 3))
        ) u_dut (
            .clock         (clock),
            .reset         (reset),
            .req_valid     (v[gi]),
            .req_ready     (rdy[gi]),
            .req_write     (wr[gi]),
            .req_size      (sz[gi]),
            .req_unsigned  (uns[gi]),
            .req_address   (addr[gi]),
            .req_write_data(wd[gi]),
            .resp_valid    (rv[gi]),
            .resp_read_data(rd[gi]),
            .resp_error    (err[gi])
        );

        always @(negedge clock) begin
            if (rv[gi]) begin
                if (exp_q[gi].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp dut%0d: got data 0x%08h err %0d at cycle %0d, expected no response",
                             gi, rd[gi], err[gi], cyc);
                end else begin
                    e_mon = exp_q[gi].pop_front();
                    $display("dut%0d txn %0d: data=0x%08h err=%0d cycle=%0d", gi, e_mon.id, rd[gi], err[gi], cyc);
                    chk($sformatf("resp_data dut%0d txn%0d", gi, e_mon.id), rd[gi], e_mon.data);
                    chk($sformatf("resp_err dut%0d txn%0d", gi, e_mon.id), 32'(err[gi]), 32'(e_mon.err));
                    chk($sformatf("resp_cycle dut%0d txn%0d", gi, e_mon.id), 32'(cyc), 32'(e_mon.cyc));
                end
            end
        end
    end

    // Called at a negedge; returns at a negedge after the accept edge.
    task automatic issue(input int i, input logic w, input logic [1:0] s, input logic u,
                         input logic [15:0] a, input logic [31:0] d,
                         input logic [31:0] ed, input logic ee,
                         input bit hold, input bit chk_gap);
        int   k;
        int   n;
        exp_t e;
        wr[i]   = w;
        sz[i]   = s;
        uns[i]  = u;
        addr[i] = a;
        wd[i]   = d;
        v[i]    = 1'b1;
        k = 0;
        while (!rdy[i] && k < 100) begin
            @(negedge clock);
            k++;
        end
        if (!rdy[i]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout dut%0d: req_ready still 0 after %0d cycles, expected 1", i, k);
            v[i] = 1'b0;
            return;
        end
        n = cyc;
        if (chk_gap) chk($sformatf("b2b_gap dut%0d", i), 32'(n - last_acc[i]), 32'(lat_of(i) + 2));
        last_acc[i] = n;
        e.data = ed;
        e.err  = ee;
        e.cyc  = n + 1 + lat_of(i);
        e.id   = tid;
        exp_q[i].push_back(e);
        tid++;
        @(negedge clock);
        if (!hold) begin
            v[i] = 1'b0;
            k = 0;
            while (!rdy[i] && k < 50) begin
                k++;
                @(negedge clock);
            end
            chk($sformatf("ready_low dut%0d", i), 32'(k), 32'(lat_of(i) + 1));
        end
    endtask

    task automatic st(input int i, input logic [1:0] s, input logic [15:0] a,
                      input logic [31:0] d, input logic ee);
        issue(i, 1'b1, s, 1'b0, a, d, 32'd0, ee, 1'b0, 1'b0);
    endtask

    task automatic ld(input int i, input logic [1:0] s, input logic u, input logic [15:0] a,
                      input logic [31:0] ed, input logic ee);
        issue(i, 1'b0, s, u, a, 32'd0, ed, ee, 1'b0, 1'b0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0; wr[i] = 1'b0; sz[i] = 2'b00; uns[i] = 1'b0;
            addr[i] = 16'd0; wd[i] = 32'd0; last_acc[i] = 0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ready dut%0d", i), 32'(rdy[i]), 32'd1);
            chk($sformatf("rst_valid dut%0d", i), 32'(rv[i]), 32'd0);
            chk($sformatf("rst_data dut%0d", i), rd[i], 32'd0);
            chk($sformatf("rst_err dut%0d", i), 32'(err[i]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clock);

        // LATENCY=1: sizes, extension, lane merge, errors
        st(1, SZ_W, 16'h0010, 32'hDEADBEEF, 1'b0);
        ld(1, SZ_W, 1'b0, 16'h0010, 32'hDEADBEEF, 1'b0);
        st(1, SZ_B, 16'h0012, 32'h0000005A, 1'b0);
        ld(1, SZ_W, 1'b0, 16'h0010, 32'hDE5ABEEF, 1'b0);
        ld(1, SZ_B, 1'b0, 16'h0013, 32'hFFFFFFDE, 1'b0);
        ld(1, SZ_B, 1'b1, 16'h0013, 32'h000000DE, 1'b0);
        ld(1, SZ_B, 1'b0, 16'h0010, 32'hFFFFFFEF, 1'b0);
        ld(1, SZ_B, 1'b1, 16'h0011, 32'h000000BE, 1'b0);
        ld(1, SZ_H, 1'b1, 16'h0012, 32'h0000DE5A, 1'b0);
        st(1, SZ_W, 16'h0020, 32'h11223344, 1'b0);
        st(1, SZ_H, 16'h0020, 32'h00008001, 1'b0);
        ld(1, SZ_H, 1'b0, 16'h0020, 32'hFFFF8001, 1'b0);
        ld(1, SZ_H, 1'b1, 16'h0020, 32'h00008001, 1'b0);
        ld(1, SZ_H, 1'b0, 16'h0022, 32'h00001122, 1'b0);
        ld(1, SZ_H, 1'b0, 16'h0021, 32'h00000000, 1'b1);
        st(1, SZ_W, 16'h0022, 32'hAAAAAAAA, 1'b1);
        ld(1, SZ_W, 1'b0, 16'h0020, 32'h11228001, 1'b0);
        st(1, SZ_W, 16'h7BBC, 32'h0BADC0DE, 1'b0);
        st(1, SZ_W, 16'h7BC0, 32'h55555555, 1'b1);
        ld(1, SZ_W, 1'b0, 16'h7BC0, 32'h00000000, 1'b1);
        ld(1, SZ_W, 1'b0, 16'h7BBC, 32'h0BADC0DE, 1'b0);
        ld(1, SZ_R, 1'b0, 16'h0010, 32'h00000000, 1'b1);

        // Reset and req_valid together: reset wins, nothing accepted
        reset = 1'b1; wr[1] = 1'b1; sz[1] = SZ_W; addr[1] = 16'h0010; wd[1] = 32'h0; v[1] = 1'b1;
        @(negedge clock);
        reset = 1'b0; v[1] = 1'b0;
        chk("rst_vs_valid_ready dut1", 32'(rdy[1]), 32'd1);
        repeat (4) @(negedge clock);
        ld(1, SZ_W, 1'b0, 16'h0010, 32'hDE5ABEEF, 1'b0);

        // LATENCY=0 and LATENCY=3: timing, back-to-back throughput
        for (int i = 0; i < 3; i += 2) begin
            st(i, SZ_W, 16'h0040, 32'hCAFEF00D, 1'b0);
            ld(i, SZ_W, 1'b0, 16'h0040, 32'hCAFEF00D, 1'b0);
            issue(i, 1'b0, SZ_H, 1'b1, 16'h0042, 32'd0, 32'h0000CAFE, 1'b0, 1'b1, 1'b0);
            issue(i, 1'b0, SZ_B, 1'b0, 16'h0041, 32'd0, 32'hFFFFFFF0, 1'b0, 1'b1, 1'b1);
            issue(i, 1'b0, SZ_W, 1'b0, 16'h0040, 32'd0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1);
        end
        st(0, SZ_B, 16'h7BBF, 32'h00000077, 1'b0);
        ld(0, SZ_B, 1'b1, 16'h7BBF, 32'h00000077, 1'b0);

        // LATENCY=3: reset during WAIT drops the store
        wr[2] = 1'b1; sz[2] = SZ_W; uns[2] = 1'b0; addr[2] = 16'h0040; wd[2] = 32'h12345678; v[2] = 1'b1;
        k = 0;
        while (!rdy[2] && k < 20) begin
            @(negedge clock);
            k++;
        end
        @(negedge clock);
        v[2] = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_wait_ready dut2", 32'(rdy[2]), 32'd1);
        chk("rst_wait_valid dut2", 32'(rv[2]), 32'd0);
        repeat (6) @(negedge clock);
        ld(2, SZ_W, 1'b0, 16'h0040, 32'hCAFEF00D, 1'b0);

        k = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && k < 200) begin
            @(negedge clock);
            k++;
        end
        chk("drain_pending", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
